uart_tx_fifo: RTL and testbench

//  Transmit side of the core's UART byte interface: buffers bytes the core pushes on uart_out/uart_wrreq
//  and serialises them onto the TX pin as 8N1 frames, LSB first. The core has no backpressure on writes,
//  so the block exposes full/count/overflow for software polling; bytes arriving while full are dropped.

---
 rtl/uart_tx_fifo_if.sv | 15 +
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle between the core and the UART transmit FIFO.
interface uart_tx_fifo_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic [7:0]          wr_data;
    logic                wrreq;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                busy;
    logic                tx;

    modport master (output wr_data, wrreq, input full, count, overflow, busy, tx);
    modport slave  (input wr_data, wrreq, output full, count, overflow, busy, tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front: buffers core writes and sends 8N1 frames LSB first.
// Writes arriving while full are dropped and flagged by a sticky overflow bit.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH_LOG2   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [7:0]            mem_q [DEPTH];

    logic pop;
    logic wr_acc;
    logic baud_exp;
    logic fifo_nonempty;

    // Next-state logic for the serialiser FSM and the FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop      = 1'b0;

        baud_exp      = (baud_q == BW'(CLKS_PER_BIT - 1));
        fifo_nonempty = (count_q != '0);

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_exp) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_exp) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_exp) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more bytes are queued.
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        wr_acc  = bus.wrreq & ~full_q;
        count_d = count_q + CW'(wr_acc) - CW'(pop);
        full_d  = (count_d == CW'(DEPTH));
        ovf_d   = ovf_q | (bus.wrreq & full_q);
        wptr_d  = wr_acc ? wptr_q + DEPTH_LOG2'(1) : wptr_q;
        rptr_d  = pop    ? rptr_q + DEPTH_LOG2'(1) : rptr_q;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= bus.wr_data;
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a 16-deep and a 4-deep instance at 4 clocks per bit,
// with a line receiver that reassembles frames from whichever tx is selected.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic sel;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    uart_tx_fifo_if #(.DEPTH_LOG2(4)) bus_b ();
    uart_tx_fifo_if #(.DEPTH_LOG2(2)) bus_s ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Line receiver: start detected at a low, each bit sampled mid-slot.
    logic       tx_mon;
    logic       rx_act;
    int         rx_idx;
    int         rx_t0;
    logic [9:0] rx_fr;
    logic [9:0] rxq[$];
    int         rxt[$];

    assign tx_mon = sel ? bus_s.tx : bus_b.tx;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (!tx_mon) begin
                rx_act <= 1'b1;
                rx_idx <= 0;
                rx_fr  <= '0;
                rx_t0  <= cyc;
            end
        end else begin
            rx_idx <= rx_idx + 1;
            if ((rx_idx + 1) % CPB == CPB / 2) rx_fr[4'((rx_idx + 1) / CPB)] <= tx_mon;
            if (rx_idx + 1 == 9 * CPB + CPB / 2) begin
                rxq.push_back({tx_mon, rx_fr[8:0]});
                rxt.push_back(rx_t0);
                rx_act <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int g_cnt();  return sel ? int'(bus_s.count)    : int'(bus_b.count);    endfunction
    function automatic int g_tx();   return sel ? int'(bus_s.tx)       : int'(bus_b.tx);       endfunction
    function automatic int g_busy(); return sel ? int'(bus_s.busy)     : int'(bus_b.busy);     endfunction
    function automatic int g_full(); return sel ? int'(bus_s.full)     : int'(bus_b.full);     endfunction
    function automatic int g_ovf();  return sel ? int'(bus_s.overflow) : int'(bus_b.overflow); endfunction

    task automatic drive(input logic w, input logic [7:0] d);
        if (sel) begin bus_s.wrreq = w; bus_s.wr_data = d; end
        else     begin bus_b.wrreq = w; bus_b.wr_data = d; end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_frame(input string nm, input logic [9:0] exp);
        if (rxq.size() == 0) begin
            chk({nm, "_missing"}, 0, 1);
        end else begin
            chk(nm, int'(rxq.pop_front()), int'(exp));
            void'(rxt.pop_front());
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic [9:0] fr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int w;
        int t0;
        logic [7:0] expq[$];
        int expc[6];

        // Frame bit i is the line level in slot i: start, d0..d7, stop.
        tbl[0] = '{8'h55, 10'h2AA};
        tbl[1] = '{8'h01, 10'h202};
        tbl[2] = '{8'h80, 10'h300};
        tbl[3] = '{8'hFF, 10'h3FE};
        tbl[4] = '{8'h00, 10'h200};
        tbl[5] = '{8'hA5, 10'h34A};
        expc   = '{1, 1, 2, 3, 4, 4};

        rst_n = 1'b0;
        sel   = 1'b0;
        bus_b.wrreq = 1'b0; bus_b.wr_data = 8'h00;
        bus_s.wrreq = 1'b0; bus_s.wr_data = 8'h00;
        repeat (3) @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            chk("rst_tx",   g_tx(),   1);
            chk("rst_busy", g_busy(), 0);
            chk("rst_cnt",  g_cnt(),  0);
            chk("rst_full", g_full(), 0);
            chk("rst_ovf",  g_ovf(),  0);
        end
        sel   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single frames from the vector table, including exact start and busy timing.
        for (int i = 0; i < 6; i++) begin
            rxq.delete(); rxt.delete();
            drive(1'b1, tbl[i].d);
            @(negedge clk);
            w = cyc;
            drive(1'b0, 8'h00);
            chk("vec_cnt1",  g_cnt(),  1);
            chk("vec_idle",  g_tx(),   1);
            chk("vec_busy0", g_busy(), 0);
            wait_cyc(w + 1);
            chk("vec_start", g_tx(),   0);
            chk("vec_busy1", g_busy(), 1);
            wait_cyc(w + 10 * CPB);
            chk("vec_busy_end", g_busy(), 1);
            wait_cyc(w + 10 * CPB + 1);
            chk("vec_busy_drop", g_busy(), 0);
            chk("vec_cnt0", g_cnt(), 0);
            if (rxt.size() > 0) chk("vec_t0", rxt[0], w + 1);
            chk_frame("vec_frame", tbl[i].fr);
            repeat (3) @(negedge clk);
        end

        // Three back-to-back frames.
        rxq.delete(); rxt.delete();
        drive(1'b1, 8'h01); @(negedge clk); w = cyc;
        chk("b2b_cnt_a", g_cnt(), 1);
        drive(1'b1, 8'h80); @(negedge clk);
        chk("b2b_cnt_b", g_cnt(), 1);
        drive(1'b1, 8'hFF); @(negedge clk);
        chk("b2b_cnt_c", g_cnt(), 2);
        drive(1'b0, 8'h00);
        wait_cyc(w + 10 * CPB);     chk("b2b_cnt_d", g_cnt(), 2);
        wait_cyc(w + 10 * CPB + 1); chk("b2b_cnt_e", g_cnt(), 1);
        chk("b2b_gap_tx", g_tx(), 0);
        wait_cyc(w + 20 * CPB + 1); chk("b2b_cnt_f", g_cnt(), 0);
        wait_cyc(w + 30 * CPB);     chk("b2b_busy1", g_busy(), 1);
        wait_cyc(w + 30 * CPB + 1); chk("b2b_busy0", g_busy(), 0);
        chk("b2b_nframes", rxq.size(), 3);
        if (rxt.size() == 3) begin
            chk("b2b_t0", rxt[0], w + 1);
            chk("b2b_t1", rxt[1], w + 1 + 10 * CPB);
            chk("b2b_t2", rxt[2], w + 1 + 20 * CPB);
        end
        chk_frame("b2b_f0", 10'h202);
        chk_frame("b2b_f1", 10'h300);
        chk_frame("b2b_f2", 10'h3FE);

        // Forty paced writes wrap the 16-entry pointers twice.
        rxq.delete(); rxt.delete();
        for (int i = 0; i < 40; i++) begin
            expq.push_back(8'(i * 37 + 5));
            drive(1'b1, 8'(i * 37 + 5));
            @(negedge clk);
            w = cyc;
            drive(1'b0, 8'h00);
            wait_cyc(w + 10 * CPB + 4);
        end
        chk("wrap_nframes", rxq.size(), 40);
        chk("wrap_ovf", g_ovf(), 0);
        while (expq.size() > 0) chk_frame("wrap_frame", {1'b1, expq.pop_front(), 1'b0});

        // Reset asserted mid-frame with bytes queued.
        rxq.delete(); rxt.delete();
        drive(1'b1, 8'hF7); @(negedge clk); w = cyc;
        drive(1'b1, 8'h11); @(negedge clk);
        drive(1'b1, 8'h22); @(negedge clk);
        drive(1'b1, 8'h33); @(negedge clk);
        drive(1'b0, 8'h00);
        wait_cyc(w + 18);
        chk("rstmid_pre_tx",  g_tx(),   0);
        chk("rstmid_pre_cnt", g_cnt(),  3);
        chk("rstmid_pre_bsy", g_busy(), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_tx",   g_tx(),   1);
        chk("rstmid_cnt",  g_cnt(),  0);
        chk("rstmid_busy", g_busy(), 0);
        chk("rstmid_full", g_full(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        wait_cyc(t0 + 100);
        chk("rstmid_noframes", rxq.size(), 0);
        chk("rstmid_busy_after", g_busy(), 0);

        // Small FIFO: six consecutive writes, last one dropped.
        sel = 1'b1;
        pulse_reset();
        rxq.delete(); rxt.delete();
        w = 0;
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 8'(8'h10 + j));
            @(negedge clk);
            if (j == 0) w = cyc;
            chk("ovf_cnt",  g_cnt(),  expc[j]);
            chk("ovf_flag", g_ovf(),  (j == 5) ? 1 : 0);
            chk("ovf_full", g_full(), (j >= 4) ? 1 : 0);
        end
        drive(1'b0, 8'h00);
        wait_cyc(w + 1 + 50 * CPB + 20);
        chk("ovf_nframes", rxq.size(), 5);
        chk("ovf_sticky",  g_ovf(),  1);
        chk("ovf_cnt_end", g_cnt(),  0);
        chk("ovf_full_end", g_full(), 0);
        for (int j = 0; j < 5; j++) chk_frame("ovf_frame", {1'b1, 8'(8'h10 + j), 1'b0});

        // Write while full on the same edge as a stop-expiry pop.
        pulse_reset();
        rxq.delete(); rxt.delete();
        chk("pop_ovf_clr", g_ovf(), 0);
        w = 0;
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 8'(8'h20 + j));
            @(negedge clk);
            if (j == 0) w = cyc;
        end
        drive(1'b0, 8'h00);
        wait_cyc(w + 10 * CPB);
        chk("pop_pre_cnt",  g_cnt(),  4);
        chk("pop_pre_full", g_full(), 1);
        chk("pop_pre_ovf",  g_ovf(),  0);
        drive(1'b1, 8'hEE);
        @(negedge clk);
        drive(1'b0, 8'h00);
        chk("pop_cnt",  g_cnt(),  3);
        chk("pop_ovf",  g_ovf(),  1);
        chk("pop_full", g_full(), 0);
        chk("pop_tx",   g_tx(),   0);
        wait_cyc(w + 1 + 50 * CPB + 10);
        chk("pop_nframes", rxq.size(), 5);
        for (int j = 0; j < 5; j++) chk_frame("pop_frame", {1'b1, 8'(8'h20 + j), 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
